// File: rtl/heat_grid_pkg.sv
// Shared types and constants for the heat-grid column sweep scheduler.
// State encoding, default widths, init slack and watchdog limit.
package heat_grid_pkg;

  localparam int NCOLS_D     = 32;
  localparam int ROW_BITS_D  = 8;
  localparam int ITER_BITS_D = 16;
  localparam int INIT_SLACK  = 4;

  localparam logic [15:0] WD_LIMIT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_ADVANCE
  } sweep_state_t;

endpackage

// File: rtl/flag_all_reduce.sv
// Registered AND-reduction of the per-column flags (1-cycle latency).
// Keeps the wide reduction off the scheduler FSM path.
module flag_all_reduce #(
  parameter int NCOLS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCOLS-1:0] i_flags,
  output logic             o_all
);

  logic r_all;

  always_ff @(posedge clk) begin
    if (reset) r_all <= 1'b0;
    else       r_all <= &i_flags;
  end

  assign o_all = r_all;

endmodule

// File: rtl/column_sweep_scheduler.sv
// Broadcasts lockstep row-step start pulses to the column engines.
// Optional stall watchdog: define COLUMN_STALL_WATCHDOG_EN.
module column_sweep_scheduler
  import heat_grid_pkg::*;
#(
  parameter int NCOLS     = NCOLS_D,
  parameter int ROW_BITS  = ROW_BITS_D,
  parameter int ITER_BITS = ITER_BITS_D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROW_BITS-1:0]  height,
  input  logic [NCOLS-1:0]     flags,
  input  logic                 run,
  input  logic                 step,
  input  logic [ITER_BITS-1:0] iter_limit,
  output logic                 start,
  output logic [ROW_BITS-1:0]  row_idx,
  output logic [ITER_BITS-1:0] sweep_cnt,
  output logic                 sweep_done,
  output logic                 busy,
  output logic                 done
`ifdef COLUMN_STALL_WATCHDOG_EN
 ,output logic                 stall,
  output logic [$clog2(NCOLS)-1:0] stall_col
`endif
);

  localparam int CTR_W = ROW_BITS + 2;

  sweep_state_t         r_state;
  logic [ROW_BITS-1:0]  r_h;
  logic [ROW_BITS-1:0]  r_row;
  logic [CTR_W-1:0]     r_init;
  logic [ITER_BITS-1:0] r_cnt;
  logic                 r_start;
  logic                 r_sweep_done;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_step_mode;

  logic                 w_all;
  logic                 w_halt;
  logic                 w_go;
  logic                 w_hit;
  logic [CTR_W-1:0]     w_init_load;
  logic [ITER_BITS-1:0] w_cnt_nxt;

  flag_all_reduce #(
    .NCOLS (NCOLS)
  ) u_reduce (
    .clk     (clk),
    .reset   (reset),
    .i_flags (flags),
    .o_all   (w_all)
  );

  // two cycles per row for memory init, plus fixed slack
  assign w_init_load = (CTR_W'(height) + CTR_W'(1)) * CTR_W'(2)
                     + CTR_W'(INIT_SLACK);

  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + ITER_BITS'(1);
  assign w_hit     = (iter_limit != '0) && (w_cnt_nxt == iter_limit);
  assign w_go      = !r_done && !w_halt && w_all && (run || step);

`ifdef COLUMN_STALL_WATCHDOG_EN
  logic [15:0]              r_wd;
  logic                     r_stall;
  logic [$clog2(NCOLS)-1:0] r_stall_col;
  logic [$clog2(NCOLS)-1:0] w_first_zero;

  always_comb begin
    w_first_zero = '0;
    for (int i = NCOLS - 1; i >= 0; i--) begin
      if (!flags[i]) w_first_zero = $clog2(NCOLS)'(i);
    end
  end

  assign w_halt    = r_stall;
  assign stall     = r_stall;
  assign stall_col = r_stall_col;
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_INIT;
      r_h          <= height;
      r_init       <= w_init_load;
      r_row        <= '0;
      r_cnt        <= '0;
      r_start      <= 1'b0;
      r_sweep_done <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_step_mode  <= 1'b0;
`ifdef COLUMN_STALL_WATCHDOG_EN
      r_wd         <= '0;
      r_stall      <= 1'b0;
      r_stall_col  <= '0;
`endif
    end else begin
      r_start      <= 1'b0;
      r_sweep_done <= 1'b0;
      unique case (r_state)
        S_INIT: begin
          if (r_init == '0) r_state <= S_IDLE;
          else              r_init  <= r_init - CTR_W'(1);
        end
        S_IDLE: begin
          if (w_go) begin
            r_state     <= S_ISSUE;
            r_start     <= 1'b1;
            r_busy      <= 1'b1;
            r_step_mode <= !run;
          end
        end
        S_ISSUE: r_state <= S_SETTLE;
        // columns clear their flags on the edge after start
        S_SETTLE: begin
          r_state <= S_WAIT;
`ifdef COLUMN_STALL_WATCHDOG_EN
          r_wd    <= '0;
`endif
        end
        S_WAIT: begin
          if (w_all) begin
            r_state <= S_ADVANCE;
            r_busy  <= 1'b0;
          end
`ifdef COLUMN_STALL_WATCHDOG_EN
          else if (r_wd == WD_LIMIT) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_stall     <= 1'b1;
            r_stall_col <= w_first_zero;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
`endif
        end
        S_ADVANCE: begin
          if (r_row != r_h) begin
            r_row   <= r_row + ROW_BITS'(1);
            r_state <= S_ISSUE;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_row        <= '0;
            r_cnt        <= w_cnt_nxt;
            r_sweep_done <= 1'b1;
            if (w_hit) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else if (r_step_mode) begin
              r_step_mode <= 1'b0;
              r_state     <= S_IDLE;
            end else if (run) begin
              r_state <= S_ISSUE;
              r_start <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign start      = r_start;
  assign row_idx    = r_row;
  assign sweep_cnt  = r_cnt;
  assign sweep_done = r_sweep_done;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_column_sweep_scheduler.sv
// Self-checking bench for column_sweep_scheduler with a column model.
// Table vectors, randomized run trials and multi-cycle corner sequences.
module tb_column_sweep_scheduler;

  localparam int NC = 32;
  localparam int RB = 8;
  localparam int IB = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RB-1:0] height = '0;
  logic [NC-1:0] flags;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic [IB-1:0] iter_limit = '0;
  logic          start;
  logic [RB-1:0] row_idx;
  logic [IB-1:0] sweep_cnt;
  logic          sweep_done;
  logic          busy;
  logic          done;
`ifdef COLUMN_STALL_WATCHDOG_EN
  logic          stall;
  logic [4:0]    stall_col;
`endif

  column_sweep_scheduler #(
    .NCOLS(NC), .ROW_BITS(RB), .ITER_BITS(IB)
  ) dut (
    .clk(clk), .reset(reset), .height(height), .flags(flags),
    .run(run), .step(step), .iter_limit(iter_limit),
    .start(start), .row_idx(row_idx), .sweep_cnt(sweep_cnt),
    .sweep_done(sweep_done), .busy(busy), .done(done)
`ifdef COLUMN_STALL_WATCHDOG_EN
   ,.stall(stall), .stall_col(stall_col)
`endif
  );

  always #5 clk = ~clk;

  // column model: clear on the start edge, raise after a delay
  logic [NC-1:0] cf;
  logic [NC-1:0] stuck = '0;
  int            cd;
  int            fix_dly = 5;
  bit            rnd_dly = 0;

  assign flags = cf & ~stuck;

  always @(posedge clk) begin
    if (reset) begin
      cf <= '1;
      cd <= 0;
    end else if (start) begin
      cf <= '0;
      cd <= rnd_dly ? int'($urandom_range(6, 1)) : fix_dly;
    end else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1) cf <= '1;
    end
  end

  // observation log
  int cyc = 0, last_rise = 0, btb = 0, sdc = 0;
  bit prev_all = 0, prev_start = 0;
  int rows[$];
  int gaps[$];

  always @(negedge clk) begin
    cyc++;
    if ((&flags) && !prev_all) last_rise = cyc;
    prev_all = &flags;
    if (start) begin
      if (prev_start) btb++;
      rows.push_back(int'(row_idx));
      gaps.push_back(cyc - last_rise);
    end
    prev_start = start;
    if (sweep_done) sdc++;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(string nm, longint got, longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_log();
    rows.delete();
    gaps.delete();
    btb = 0;
    sdc = 0;
  endtask

  task automatic do_reset(int h, bit r);
    reset = 1'b1;
    height = RB'(h);
    run = r;
    step = 1'b0;
    stuck = '0;
    tick(2);
    clear_log();
    reset = 1'b0;
    height = RB'(h) ^ 8'h5A;
  endtask

  // INIT holds 2*(h+1)+4 decrements plus the zero cycle, then IDLE, then ISSUE
  task automatic wait_first_start(string nm, int h);
    int n = 0;
    while (!start && n < 600) begin
      tick();
      n++;
    end
    check({nm, "_first_start"}, n, 2 * (h + 1) + 6);
    check({nm, "_first_row"}, row_idx, 0);
  endtask

  task automatic check_episode(string nm, int h, int xs, int xc, bit xd);
    check({nm, "_starts"}, rows.size(), xs);
    for (int k = 0; k < rows.size(); k++) begin
      check($sformatf("%s_row%0d", nm, k), rows[k], k % (h + 1));
      if (k > 0) check($sformatf("%s_gap%0d", nm, k), gaps[k], 3);
    end
    check({nm, "_back2back"}, btb, 0);
    check({nm, "_sweep_cnt"}, sweep_cnt, xc);
    check({nm, "_sweep_done_n"}, sdc, xc);
    check({nm, "_done"}, done, xd);
    check({nm, "_busy"}, busy, 0);
  endtask

  task automatic run_episode(string nm, int h, bit use_run, int lim,
                             int xs, int xc, bit xd);
    int n;
    iter_limit = IB'(lim);
    if (use_run) begin
      do_reset(h, 1'b1);
      wait_first_start(nm, h);
      n = 0;
      while (!done && n < 5000) begin
        tick();
        n++;
      end
      tick(20);
      run = 1'b0;
    end else begin
      do_reset(h, 1'b0);
      tick(2 * (h + 1) + 10);
      step = 1'b1; tick(); step = 1'b0;
      tick(2);
      step = 1'b1; tick(); step = 1'b0;
      n = 0;
      while (sdc < 1 && n < 5000) begin
        tick();
        n++;
      end
      tick(20);
    end
    check_episode(nm, h, xs, xc, xd);
    if (xd) begin
      // done is sticky: a raised limit, step or run must not restart
      iter_limit = iter_limit + IB'(5);
      step = 1'b1; tick(); step = 1'b0;
      run = 1'b1;
      tick(30);
      run = 1'b0;
      check({nm, "_post_done_starts"}, rows.size(), xs);
      check({nm, "_post_done_done"}, done, 1);
    end
  endtask

  typedef struct {
    int h;
    bit use_run;
    int lim;
    int dly;
    int xs;
    int xc;
    bit xd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n, n0, h, lim;

    vecs[0] = '{h: 7, use_run: 1, lim: 2, dly: 5, xs: 16, xc: 2, xd: 1};
    vecs[1] = '{h: 3, use_run: 0, lim: 0, dly: 5, xs: 4,  xc: 1, xd: 0};
    vecs[2] = '{h: 0, use_run: 1, lim: 3, dly: 2, xs: 3,  xc: 3, xd: 1};
    vecs[3] = '{h: 2, use_run: 0, lim: 1, dly: 1, xs: 3,  xc: 1, xd: 1};
    vecs[4] = '{h: 1, use_run: 1, lim: 1, dly: 4, xs: 2,  xc: 1, xd: 1};

    tick(3);
    check("reset_start", start, 0);
    check("reset_row", row_idx, 0);
    check("reset_cnt", sweep_cnt, 0);
    check("reset_sweep_done", sweep_done, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    for (int i = 0; i < 5; i++) begin
      fix_dly = vecs[i].dly;
      run_episode($sformatf("vec%0d", i), vecs[i].h, vecs[i].use_run,
                  vecs[i].lim, vecs[i].xs, vecs[i].xc, vecs[i].xd);
    end

    // randomized run trials against the arithmetic reference
    rnd_dly = 1;
    for (int t = 0; t < 6; t++) begin
      h   = int'($urandom_range(5, 0));
      lim = int'($urandom_range(3, 1));
      run_episode($sformatf("rnd%0d_h%0d_l%0d", t, h, lim), h, 1'b1, lim,
                  lim * (h + 1), lim, 1'b1);
    end
    rnd_dly = 0;
    fix_dly = 5;

    // one column held low in WAIT
    iter_limit = '0;
    do_reset(3, 1'b1);
    wait_first_start("stuck", 3);
    n = 0;
    while (rows.size() < 2 && n < 200) begin
      tick();
      n++;
    end
    stuck = 32'h0000_0200;
    n0 = rows.size();
    tick(100);
    check("stuck_no_start", rows.size(), n0);
    check("stuck_busy", busy, 1);
    stuck = '0;
    n = 0;
    while (!start && n < 20) begin
      tick();
      n++;
    end
    check("stuck_release_latency", n, 3);
    check("stuck_row", row_idx, 2);
    run = 1'b0;
    tick(60);

    // reset while waiting at row 4 of the second sweep
    do_reset(5, 1'b1);
    wait_first_start("midrst", 5);
    n = 0;
    while (!(start && row_idx == 4 && sweep_cnt == 1) && n < 1000) begin
      tick();
      n++;
    end
    check("midrst_reached", row_idx, 4);
    tick(2);
    reset = 1'b1;
    height = 8'd5;
    tick();
    check("midrst_start", start, 0);
    check("midrst_row", row_idx, 0);
    check("midrst_cnt", sweep_cnt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sweep_done", sweep_done, 0);
    clear_log();
    reset = 1'b0;
    wait_first_start("midrst_again", 5);
    run = 1'b0;
    tick(80);

`ifdef COLUMN_STALL_WATCHDOG_EN
    do_reset(1, 1'b1);
    wait_first_start("wd", 1);
    stuck = 32'h0000_0020;
    n = 0;
    while (!stall && n < 70000) begin
      tick();
      n++;
    end
    check("wd_stall", stall, 1);
    check("wd_stall_col", stall_col, 5);
    check("wd_busy", busy, 0);
    n0 = rows.size();
    tick(50);
    check("wd_no_more_start", rows.size(), n0);
    run = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
